// File: rtl/mv_pkg.sv
// Shared types and constants for the GRU matrix-vector operand loader.
// Holds the loader state encoding, default sizes and counter-width helper.
package mv_pkg;

   typedef enum logic [1:0] {
      LOAD_W = 2'd0,
      LOAD_B = 2'd1,
      SETTLE = 2'd2,
      DRAIN  = 2'd3
   } mv_state_e;

   localparam int MV_X_DEF  = 2;
   localparam int MV_H_DEF  = 2;
   localparam int MV_DW_DEF = 8;

   // Width of a counter that runs 0..limit-1, never narrower than one bit.
   function automatic int cnt_w(input int limit);
      return (limit <= 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/mv_result_serializer.sv
// Result register and element-by-element drain of the multiplier output.
// Capture is strobed by the loader FSM; active marks the DRAIN state.
module mv_result_serializer
   import mv_pkg::*;
#(
   parameter int H          = MV_H_DEF,
   parameter int DATA_WIDTH = MV_DW_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      capture,
   input  logic                      active,
   input  logic [0:H*DATA_WIDTH-1]   c_in,
   input  logic                      r_ready,
   output logic [DATA_WIDTH-1:0]     r_data,
   output logic                      r_valid,
   output logic                      r_last,
   output logic                      done
);

   localparam int RCW = cnt_w(H);
   localparam logic [RCW-1:0] R_LAST = RCW'(H - 1);

   logic [0:H*DATA_WIDTH-1] result_q, result_d;
   logic [RCW-1:0]          r_cnt_q, r_cnt_d;
   logic                    hs;

   always_comb begin
      result_d = result_q;
      r_cnt_d  = r_cnt_q;
      r_valid  = active && !rst;
      r_last   = r_valid && (r_cnt_q == R_LAST);
      hs       = r_valid && r_ready;
      done     = hs && r_last;
      r_data   = '0;
      for (int k = 0; k < H; k++) begin
         if (r_cnt_q == RCW'(k)) begin
            r_data = result_q[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (capture) begin
         result_d = c_in;
         r_cnt_d  = '0;
      end
      if (hs) begin
         r_cnt_d = done ? '0 : r_cnt_q + RCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         r_cnt_q  <= '0;
      end else begin
         result_q <= result_d;
         r_cnt_q  <= r_cnt_d;
      end
   end

endmodule

// File: rtl/mv_operand_loader.sv
// Byte-stream front/back end for the approximate GRU matrix-vector multiplier.
// Optional MV_WEIGHT_HOLD_EN adds hold_w to reuse weights across frames.
module mv_operand_loader
   import mv_pkg::*;
#(
   parameter int X          = MV_X_DEF,
   parameter int H          = MV_H_DEF,
   parameter int DATA_WIDTH = MV_DW_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic                      s_last,
   output logic [0:X*H*DATA_WIDTH-1] a_out,
   output logic [0:X*DATA_WIDTH-1]   b_out,
   input  logic [0:H*DATA_WIDTH-1]   c_in,
   output logic [DATA_WIDTH-1:0]     r_data,
   output logic                      r_valid,
   input  logic                      r_ready,
   output logic                      r_last,
`ifdef MV_WEIGHT_HOLD_EN
   input  logic                      hold_w,
`endif
   output logic                      frame_err
);

   localparam int WCW = cnt_w(X * H);
   localparam int VCW = cnt_w(X);
   localparam logic [WCW-1:0] W_LAST = WCW'(X * H - 1);
   localparam logic [VCW-1:0] V_LAST = VCW'(X - 1);

   mv_state_e                 state_q, state_d;
   logic [WCW-1:0]            w_cnt_q, w_cnt_d;
   logic [VCW-1:0]            v_cnt_q, v_cnt_d;
   logic [0:X*H*DATA_WIDTH-1] a_q, a_d;
   logic [0:X*DATA_WIDTH-1]   b_q, b_d;
   logic                      frame_err_q, frame_err_d;
   logic                      beat;
   logic                      capture;
   logic                      drain_done;

   always_comb begin
      state_d     = state_q;
      w_cnt_d     = w_cnt_q;
      v_cnt_d     = v_cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      frame_err_d = 1'b0;
      capture     = 1'b0;
      s_ready     = ((state_q == LOAD_W) || (state_q == LOAD_B)) && !rst;
      beat        = s_valid && s_ready;

      case (state_q)
         LOAD_W: begin
            if (beat) begin
               for (int k = 0; k < X * H; k++) begin
                  if (w_cnt_q == WCW'(k)) a_d[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
               end
               if (s_last) begin
                  frame_err_d = 1'b1;
                  w_cnt_d     = '0;
                  v_cnt_d     = '0;
               end else if (w_cnt_q == W_LAST) begin
                  w_cnt_d = '0;
                  state_d = LOAD_B;
               end else begin
                  w_cnt_d = w_cnt_q + WCW'(1);
               end
            end
         end
         LOAD_B: begin
            if (beat) begin
               for (int k = 0; k < X; k++) begin
                  if (v_cnt_q == VCW'(k)) b_d[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
               end
               // A late or missing s_last still completes the frame; only an early one aborts it.
               if (s_last && (v_cnt_q != V_LAST)) begin
                  frame_err_d = 1'b1;
                  w_cnt_d     = '0;
                  v_cnt_d     = '0;
                  state_d     = LOAD_W;
               end else if (v_cnt_q == V_LAST) begin
                  frame_err_d = !s_last;
                  v_cnt_d     = '0;
                  state_d     = SETTLE;
               end else begin
                  v_cnt_d = v_cnt_q + VCW'(1);
               end
            end
         end
         SETTLE: begin
            capture = 1'b1;
            state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_done) begin
`ifdef MV_WEIGHT_HOLD_EN
               state_d = hold_w ? LOAD_B : LOAD_W;
`else
               state_d = LOAD_W;
`endif
            end
         end
         default: state_d = LOAD_W;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LOAD_W;
         w_cnt_q     <= '0;
         v_cnt_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_cnt_q     <= w_cnt_d;
         v_cnt_q     <= v_cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign frame_err = frame_err_q && !rst;

   mv_result_serializer #(
      .H          (H),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_serializer (
      .clk     (clk),
      .rst     (rst),
      .capture (capture),
      .active  (state_q == DRAIN),
      .c_in    (c_in),
      .r_ready (r_ready),
      .r_data  (r_data),
      .r_valid (r_valid),
      .r_last  (r_last),
      .done    (drain_done)
   );

endmodule

// File: tb/tb_mv_operand_loader.sv
// Randomized self-checking bench for mv_operand_loader against a frame-level model.
// Scenario 6 (weight hold) runs only when MV_WEIGHT_HOLD_EN is defined.
module tb_mv_operand_loader;

   localparam int X  = 2;
   localparam int H  = 2;
   localparam int DW = 8;

   typedef logic [7:0] byteq_t[$];

   logic                clk = 1'b0;
   logic                rst;
   logic [DW-1:0]       s_data;
   logic                s_valid;
   logic                s_ready;
   logic                s_last;
   logic [0:X*H*DW-1]   a_out;
   logic [0:X*DW-1]     b_out;
   logic [0:H*DW-1]     c_in;
   logic [DW-1:0]       r_data;
   logic                r_valid;
   logic                r_ready;
   logic                r_last;
   logic                frame_err;
`ifdef MV_WEIGHT_HOLD_EN
   logic                hold_w;
`endif

   int passCount  = 0;
   int checkCount = 0;

   // Reference model: operand contents and whether the next frame reuses weights.
   logic [7:0] mA[X*H];
   logic [7:0] mB[X];
   bit         holdActive;

   mv_operand_loader #(.X(X), .H(H), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_last    (s_last),
      .a_out     (a_out),
      .b_out     (b_out),
      .c_in      (c_in),
      .r_data    (r_data),
      .r_valid   (r_valid),
      .r_ready   (r_ready),
      .r_last    (r_last),
`ifdef MV_WEIGHT_HOLD_EN
      .hold_w    (hold_w),
`endif
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [63:0] expA();
      logic [63:0] v = '0;
      for (int j = 0; j < X * H; j++) v = (v << 8) | 64'(mA[j]);
      return v;
   endfunction

   function automatic logic [63:0] expB();
      logic [63:0] v = '0;
      for (int j = 0; j < X; j++) v = (v << 8) | 64'(mB[j]);
      return v;
   endfunction

   function automatic void clearModel();
      for (int j = 0; j < X * H; j++) mA[j] = '0;
      for (int j = 0; j < X; j++) mB[j] = '0;
      holdActive = 1'b0;
   endfunction

   function automatic byteq_t randBeats(input int n);
      byteq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic sendBeat(input logic [7:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      s_data  = d;
      s_valid = 1'b1;
      s_last  = l;
      while (!s_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) checkOutput("sready_timeout", 64'(s_ready), 64'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'($urandom);
   endtask

   task automatic applyStimulus(input byteq_t beats, input int errPos, input bit dropLast,
                                input bit useGaps, input int bp, input bit holdNext,
                                input int resetAfter, input logic [15:0] cval);
      int  base;
      int  nSend;
      bit  early;
      bit  l;
      int  nb;
      logic [7:0] ev;
      c_in  = cval;
      base  = holdActive ? X * H : 0;
      early = (errPos >= 0) && (errPos < beats.size() - 1);
      nSend = early ? errPos + 1 : beats.size();
      for (int i = 0; i < nSend; i++) begin
         l = early ? (i == errPos) : ((i == nSend - 1) && !dropLast);
         if (useGaps) @(negedge clk);
         sendBeat(beats[i], l);
         if (base + i < X * H) mA[base + i] = beats[i];
         else mB[base + i - X * H] = beats[i];
      end

      if (early) begin
         checkOutput("err_pulse", 64'(frame_err), 64'd1);
         checkOutput("err_sready", 64'(s_ready), 64'd1);
         checkOutput("err_rvalid", 64'(r_valid), 64'd0);
         checkOutput("err_a_out", 64'(a_out), expA());
         checkOutput("err_b_out", 64'(b_out), expB());
         @(posedge clk);
         #1;
         checkOutput("err_once", 64'(frame_err), 64'd0);
         checkOutput("err_no_result", 64'(r_valid), 64'd0);
         holdActive = 1'b0;
         return;
      end

      checkOutput("settle_sready", 64'(s_ready), 64'd0);
      checkOutput("settle_rvalid", 64'(r_valid), 64'd0);
      checkOutput("slast_err", 64'(frame_err), 64'(dropLast));
      checkOutput("a_out", 64'(a_out), expA());
      checkOutput("b_out", 64'(b_out), expB());
      @(posedge clk);
      #1;
      checkOutput("latency_rvalid", 64'(r_valid), 64'd1);
      checkOutput("err_cleared", 64'(frame_err), 64'd0);
      c_in = ~cval;

      for (int k = 0; k < H; k++) begin
         ev = 8'(cval >> ((H - 1 - k) * 8));
         nb = (bp >= 0) ? bp : int'($urandom_range(0, 3));
         repeat (nb) begin
            @(negedge clk);
            r_ready = 1'b0;
            s_valid = 1'($urandom);
            s_data  = 8'($urandom);
            checkOutput("bp_rdata", 64'(r_data), 64'(ev));
            checkOutput("bp_rlast", 64'(r_last), 64'(k == H - 1));
            checkOutput("bp_rvalid", 64'(r_valid), 64'd1);
            checkOutput("bp_sready", 64'(s_ready), 64'd0);
         end
         if (resetAfter == k) begin
            @(negedge clk);
            rst     = 1'b1;
            r_ready = 1'b0;
            s_valid = 1'b0;
            #1;
            checkOutput("rst_rvalid", 64'(r_valid), 64'd0);
            checkOutput("rst_sready", 64'(s_ready), 64'd0);
            checkOutput("rst_rlast", 64'(r_last), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            checkOutput("post_rst_rvalid", 64'(r_valid), 64'd0);
            checkOutput("post_rst_sready", 64'(s_ready), 64'd1);
            checkOutput("post_rst_a", 64'(a_out), 64'd0);
            checkOutput("post_rst_b", 64'(b_out), 64'd0);
            checkOutput("post_rst_err", 64'(frame_err), 64'd0);
            clearModel();
            return;
         end
         @(negedge clk);
         r_ready = 1'b1;
`ifdef MV_WEIGHT_HOLD_EN
         hold_w = holdNext;
`endif
         checkOutput("rdata", 64'(r_data), 64'(ev));
         checkOutput("rlast", 64'(r_last), 64'(k == H - 1));
         checkOutput("rvalid", 64'(r_valid), 64'd1);
         checkOutput("drain_sready", 64'(s_ready), 64'd0);
         @(posedge clk);
         #1;
         r_ready = 1'b0;
         s_valid = 1'b0;
      end
      checkOutput("done_rvalid", 64'(r_valid), 64'd0);
      checkOutput("done_sready", 64'(s_ready), 64'd1);
`ifdef MV_WEIGHT_HOLD_EN
      hold_w     = 1'b0;
      holdActive = holdNext;
`else
      holdActive = 1'b0;
`endif
   endtask

   initial begin
      byteq_t s1;
      byteq_t q;
      int     n;
      int     errPos;
      bit     hn;
      s1 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h05, 8'h06};
      rst     = 1'b1;
      s_data  = '0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      r_ready = 1'b0;
      c_in    = '0;
`ifdef MV_WEIGHT_HOLD_EN
      hold_w  = 1'b0;
`endif
      clearModel();

      @(negedge clk);
      checkOutput("reset_sready", 64'(s_ready), 64'd0);
      checkOutput("reset_rvalid", 64'(r_valid), 64'd0);
      checkOutput("reset_ferr", 64'(frame_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset_exit_sready", 64'(s_ready), 64'd1);
      checkOutput("reset_a", 64'(a_out), 64'd0);
      checkOutput("reset_b", 64'(b_out), 64'd0);

      $display("[TB] scenario 1: basic frame");
      applyStimulus(s1, -1, 1'b0, 1'b0, 0, 1'b0, -1, 16'hAABB);
      checkOutput("s1_a", 64'(a_out), 64'h10203040);
      checkOutput("s1_b", 64'(b_out), 64'h0506);

      $display("[TB] scenario 2: backpressure");
      applyStimulus(s1, -1, 1'b0, 1'b0, 3, 1'b0, -1, 16'hAABB);

      $display("[TB] scenario 3: s_valid gaps");
      applyStimulus(s1, -1, 1'b0, 1'b1, 0, 1'b0, -1, 16'hAABB);
      checkOutput("s3_a", 64'(a_out), 64'h10203040);

      $display("[TB] scenario 4: early s_last");
      applyStimulus(s1, 1, 1'b0, 1'b0, 0, 1'b0, -1, 16'hAABB);
      applyStimulus(randBeats(X * H + X), -1, 1'b0, 1'b0, -1, 1'b0, -1, 16'($urandom));

      $display("[TB] scenario 5: reset mid-drain");
      applyStimulus(s1, -1, 1'b0, 1'b0, 0, 1'b0, 1, 16'hAABB);
      applyStimulus(s1, -1, 1'b0, 1'b0, 0, 1'b0, -1, 16'h1234);

`ifdef MV_WEIGHT_HOLD_EN
      $display("[TB] scenario 6: weight hold");
      applyStimulus(s1, -1, 1'b0, 1'b0, 0, 1'b1, -1, 16'hAABB);
      applyStimulus('{8'h07, 8'h08}, -1, 1'b0, 1'b0, 0, 1'b0, -1, 16'hC3D4);
      checkOutput("s6_a", 64'(a_out), 64'h10203040);
      checkOutput("s6_b", 64'(b_out), 64'h0708);
`endif

      $display("[TB] randomized frames");
      for (int f = 0; f < 30; f++) begin
         n      = holdActive ? X : X * H + X;
         q      = randBeats(n);
         errPos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 2)) : -1;
`ifdef MV_WEIGHT_HOLD_EN
         hn = 1'($urandom);
`else
         hn = 1'b0;
`endif
         applyStimulus(q, errPos, ($urandom_range(0, 5) == 0), 1'($urandom), -1, hn,
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, H - 1)) : -1,
                       16'($urandom));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
